// File: rtl/logic_gate_pkg.sv
// Op encoding and the bitwise gate evaluator shared by the pipe.
package logic_gate_pkg;

  localparam int MAXW = 64;

  typedef enum logic [2:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_NAND    = 3'd2,
    OP_NOR     = 3'd3,
    OP_XOR     = 3'd4,
    OP_XNOR    = 3'd5,
    OP_NOTA    = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  // Returns {result, err}; callers zero-extend operands and keep the low bits.
  function automatic logic [MAXW:0] gate_eval(input logic [MAXW-1:0] a,
                                              input logic [MAXW-1:0] b,
                                              input op_e             op);
    logic [MAXW-1:0] r;
    logic            e;
    r = '0;
    e = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOTA: r = ~a;
      default: e = 1'b1;
    endcase
    return {r, e};
  endfunction

endpackage

// File: rtl/res_fifo.sv
// Result FIFO with a registered head: 1-cycle write-to-head, head holds its last value when empty.
// Full drops pushes, empty ignores pops; head only changes on a pop or a push into an empty FIFO.
module res_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            din_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            dout_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] head_q, head_d;
  logic          wr_en, rd_en;

  assign wr_en  = push_i && (cnt_q != FULL_CNT);
  assign rd_en  = pop_i && (cnt_q != '0);
  assign rd_nxt = rd_ptr_q + 1'b1;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    if (wr_en && !rd_en) begin
      cnt_d = cnt_q + 1'b1;
    end else if (rd_en && !wr_en) begin
      cnt_d = cnt_q - 1'b1;
    end
    // With one entry left, a pop exposes whatever is pushed at the same edge.
    if (rd_en) begin
      if (cnt_q > ONE_CNT) begin
        head_d = mem_q[rd_nxt];
      end else if (wr_en) begin
        head_d = din_i;
      end
    end else if (wr_en && (cnt_q == '0)) begin
      head_d = din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_nxt;
    end
  end

  assign dout_o = head_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/logic_gate_pipe.sv
// Bitwise gate unit feeding a DEPTH-entry result FIFO; result visible 1 cycle after acceptance.
// in_ready depends only on registered occupancy, so out_ready never reaches it combinationally.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err,
  output logic [15:0]      txn_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0] cnt;
  logic          push, pop;
  logic [MAXW:0] res_full;
  logic [WIDTH:0] din, dout;
  logic [15:0]   txn_cnt_q, txn_cnt_d;

  assign in_ready  = rst_n && (cnt < FULL_CNT);
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign res_full = gate_eval(MAXW'(a), MAXW'(b), op_e'(op));
  assign din      = res_full[WIDTH:0];

  generate
    if (WIDTH < MAXW) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^res_full[MAXW:WIDTH+1];
    end
  endgenerate

  res_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .din_i  (din),
    .pop_i  (pop),
    .dout_o (dout),
    .cnt_o  (cnt)
  );

  assign y   = dout[WIDTH:1];
  assign err = dout[0];

  assign txn_cnt_d = txn_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt_q <= '0;
    end else if (push) begin
      txn_cnt_q <= txn_cnt_d;
    end
  end

  assign txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomized and directed bench for logic_gate_pipe against a queue-based reference model.
module tb_logic_gate_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic       in_ready, out_valid, err;
  logic [7:0] y;
  logic [15:0] txn_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [8:0]  mq[$];
  logic [8:0]  hold = '0;
  logic [15:0] m_txn = '0;
  bit          m_acc;

  // Per-op truth table indexed by {a_bit, b_bit}.
  logic [3:0] lut [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                          4'b0110, 4'b1001, 4'b0011, 4'b0000};
  logic [7:0] tt_exp [7] = '{8'h03, 8'h3F, 8'hFC, 8'hC0, 8'h3C, 8'hC3, 8'hF0};

  logic_gate_pipe #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .err       (err),
    .txn_cnt   (txn_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ref_op(input logic [7:0] ra, input logic [7:0] rb,
                                        input logic [2:0] rop);
    logic [7:0] r;
    logic [3:0] t;
    r = '0;
    if (rop == 3'd7) return {8'h00, 1'b1};
    t = lut[rop];
    for (int i = 0; i < 8; i++) r[i] = t[{ra[i], rb[i]}];
    return {r, 1'b0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      m_acc = in_valid && (mq.size() < 2);
      if (mq.size() != 0 && out_ready) hold = mq.pop_front();
      if (m_acc) begin
        mq.push_back(ref_op(a, b, op));
        m_txn = m_txn + 16'd1;
      end
    end
  end

  always @(negedge rst_n) begin
    mq.delete();
    hold  = '0;
    m_txn = '0;
  end

  always @(negedge clk) begin
    logic [8:0] eh;
    if (chk_en) begin
      eh = (mq.size() != 0) ? mq[0] : hold;
      check("out_valid", out_valid, mq.size() != 0);
      check("in_ready", in_ready, rst_n && (mq.size() < 2));
      check("y", y, eh[8:1]);
      check("err", err, eh[0]);
      check("txn_cnt", txn_cnt, m_txn);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_txn", txn_cnt, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("rel_in_ready", in_ready, 1);

    // Truth table with out_ready held high.
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a = 8'h0F; b = 8'h33; op = 3'(i);
      step();
      check("tt_y", y, tt_exp[i]);
      check("tt_err", err, 0);
      check("tt_valid", out_valid, 1);
    end
    a = 8'hFF; b = 8'hFF; op = 3'd7;
    step();
    check("ill_y", y, 8'h00);
    check("ill_err", err, 1);
    check("ill_txn", txn_cnt, 16'd8);
    in_valid = 1'b0;
    step();

    // Backpressure: three requests against a two-entry FIFO.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op = 3'd1; a = 8'h01; b = 8'h02;
    step();
    a = 8'h04; b = 8'h08;
    step();
    a = 8'h10; b = 8'h20;
    #1 check("bp_in_ready", in_ready, 0);
    step();
    step();
    check("bp_txn_held", txn_cnt, 16'd10);
    check("bp_head", y, 8'h03);
    out_ready = 1'b1;
    step();
    check("bp_pop1", y, 8'h0C);
    check("bp_txn_nopush", txn_cnt, 16'd10);
    step();
    check("bp_pop2", y, 8'h30);
    check("bp_txn_third", txn_cnt, 16'd11);
    in_valid = 1'b0;
    step();
    check("bp_empty", out_valid, 0);
    check("bp_hold_y", y, 8'h30);
    step();

    // Streaming: one in, one out per cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
      step();
      check("st_valid", out_valid, 1);
      check("st_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    // txn_cnt wrap.
    force dut.txn_cnt_q = 16'hFFFE;
    m_txn = 16'hFFFE;
    #1 release dut.txn_cnt_q;
    in_valid = 1'b1;
    op = 3'd4; a = 8'hA5; b = 8'h5A;
    repeat (3) step();
    check("wrap_txn", txn_cnt, 16'h0001);
    in_valid = 1'b0;
    step();

    // Reset with two entries queued.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op = 3'd0; a = 8'hFF; b = 8'h81;
    step();
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_y", y, 0);
    check("mr_err", err, 0);
    check("mr_txn", txn_cnt, 0);
    check("mr_in_ready", in_ready, 0);
    step();
    #2 rst_n = 1'b1;
    #1 check("mr_rel_ready", in_ready, 1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op = 3'd0; a = 8'hF0; b = 8'h3C;
    step();
    check("mr_new_y", y, 8'h30);
    check("mr_new_valid", out_valid, 1);
    check("mr_new_txn", txn_cnt, 16'd1);
    in_valid = 1'b0;
    repeat (2) step();
    check("mr_drained", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result bit width (legal values 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of result FIFO entries (power of 2, minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand request present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port op, input, 3 bits: operation select.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the FIFO head holds a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the head this cycle.
REQ-011 The block SHALL have port y, output, WIDTH bits: the result at the FIFO head.
REQ-012 The block SHALL have port err, output, 1 bit: the head result came from an illegal op.
REQ-013 The block SHALL have port txn_cnt, output, 16 bits: count of accepted requests.

Function
REQ-014 Op encoding SHALL be: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a (b ignored), 7 illegal.
REQ-015 Op 7 SHALL produce result 0 with err=1; every other op SHALL produce err=0.
REQ-016 Operations SHALL be bitwise across all WIDTH bits, with no carry or cross-bit interaction.
REQ-017 A request SHALL be accepted when in_valid && in_ready at a rising clk edge.
REQ-018 An accepted request SHALL have its {y, err} computed and written into the FIFO at that same edge.
REQ-019 Latency SHALL be exactly 1 cycle: out_valid is high in the cycle after acceptance, when the FIFO was empty.
REQ-020 in_ready SHALL equal (count < DEPTH) and SHALL be a function of registered state only, with no combinational path from out_ready.
REQ-021 A pop SHALL occur when out_valid && out_ready; y and err SHALL then advance to the next entry at the next edge.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-023 When full, in_valid SHALL be ignored and txn_cnt SHALL NOT increment.
REQ-024 When empty, out_ready SHALL be ignored; y and err SHALL hold their last values, and out_valid SHALL be 0.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 The count SHALL have range 0..DEPTH and be log2(DEPTH)+1 bits wide.
REQ-027 txn_cnt SHALL increment by 1 on each acceptance and wrap from 0xFFFF to 0x0000.
REQ-028 Once out_valid is asserted, y and err SHALL remain stable until popped.

Reset
REQ-029 When rst_n=0, the block SHALL immediately clear count, both pointers and txn_cnt, and drive out_valid=0, y=0, err=0, in_ready=0.
REQ-030 After rst_n deasserts, in_ready SHALL become 1 in the first cycle; no clock edge SHALL be required.
REQ-031 A reset asserted mid-operation SHALL discard all queued results without any partial pop being visible.

Structure
REQ-032 Package logic_gate_pkg SHALL hold the op enum (OP_AND..OP_ILLEGAL) and a function computing {result, err} from a, b and op.
REQ-033 The FIFO SHALL be a sub-module, res_fifo, parametrised by data width (WIDTH+1) and DEPTH.
REQ-034 logic_gate_pipe SHALL contain the op decode, the handshake glue and txn_cnt.

Verification
REQ-035 Truth table, WIDTH=8: a=0x0F, b=0x33, ops 0..6 -> y=0x03, 0x3F, 0xFC, 0xC0, 0x3C, 0xC3, 0xF0 with err=0, each 1 cycle after acceptance.
REQ-036 Illegal op: op=7, a=0xFF, b=0xFF -> y=0x00, err=1, txn_cnt increments.
REQ-037 Backpressure: out_ready=0 with 3 requests offered -> first 2 accepted; in_ready=0 on the third and it is held; out_ready=1 then drains in order, and the third is accepted after the first pop.
REQ-038 Streaming: in_valid=out_ready=1 for 20 cycles -> one result per cycle, in order, and count stays at 1.
REQ-039 Wrap: preload txn_cnt near 0xFFFF by 65 537 accepts, or by force in simulation -> txn_cnt reads 0x0001 after the last accept.
REQ-040 Reset mid-stream: rst_n=0 with 2 entries queued -> out_valid=0, y=0, txn_cnt=0 immediately; after release, a new request gives its result with no stale data.
